// File: rtl/us_cmd_pkg.sv
// Shared constants and controller state type for the upstream command FIFO arbiter.
package us_cmd_pkg;
  localparam int CMD_W     = 128;
  localparam int MAX_BEATS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } us_arb_state_t;
endpackage

// File: rtl/us_cmd_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping mod N.
module rr_arbiter #(
  parameter int  N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan farthest-first so the requester nearest the pointer is written last and wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_add(ptr_i, k)]) begin
        gnt_idx_o = wrap_add(ptr_i, k);
        gnt_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/us_cmd_arb.sv
// Round-robin packet scheduler in front of the upstream command FIFO write port.
module us_cmd_arb #(
  parameter int  N         = 3,
  parameter int  CMD_W     = us_cmd_pkg::CMD_W,
  parameter int  MAX_BEATS = us_cmd_pkg::MAX_BEATS,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*CMD_W-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [CMD_W-1:0]     fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  input  logic                 fifo_prog_full,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 len_err,
  output logic [31:0]          pkt_count
);
  import us_cmd_pkg::*;

  // Beat counter saturates one past the legal maximum; that value marks an overlong packet.
  localparam int CW = $clog2(MAX_BEATS + 2);

  us_arb_state_t    state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    beats_q, beats_d;
  logic             len_err_q, len_err_d;
  logic [31:0]      pkt_q, pkt_d;

  logic [IW-1:0]    arb_idx;
  logic             arb_vld;
  logic             sel_valid, sel_last, accept;
  logic [CMD_W-1:0] sel_data;

  rr_arbiter #(.N(N)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = req_data[grant_q*CMD_W +: CMD_W];
  assign accept    = (state_q == XFER) && sel_valid && !fifo_full;

  always_comb begin
    req_ready = '0;
    if (state_q == XFER && !fifo_full) req_ready[grant_q] = 1'b1;
  end

  assign fifo_wr_en = accept;
  assign fifo_din   = accept ? sel_data : '0;

  // prog_full only gates packet start; a granted packet runs to its last beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    beats_d   = beats_q;
    len_err_d = len_err_q;
    pkt_d     = pkt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld && !fifo_prog_full) begin
          grant_d = arb_idx;
          beats_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (beats_q != CW'(MAX_BEATS + 1)) beats_d = beats_q + 1'b1;
          if (beats_q == CW'(MAX_BEATS)) len_err_d = 1'b1;
          if (sel_last) begin
            rr_ptr_d = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
            pkt_d    = pkt_q + 32'd1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      beats_q   <= '0;
      len_err_q <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      beats_q   <= beats_d;
      len_err_q <= len_err_d;
      pkt_q     <= pkt_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);
  assign len_err   = len_err_q;
  assign pkt_count = pkt_q;
endmodule

// File: tb/tb_us_cmd_arb.sv
// Directed bench: per-source packet queues, FIFO flag model, and a write scoreboard.
module tb_us_cmd_arb;
  localparam int N = 3, CMD_W = 128, IW = 2, DEPTH = 16, PF_TH = 12;

  typedef struct { logic [CMD_W-1:0] d; logic l; } beat_t;
  typedef struct { logic [CMD_W-1:0] d; int src; } exp_t;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [N-1:0]         req_valid = '0, req_last = '0, req_ready;
  logic [N*CMD_W-1:0]   req_data = '0;
  logic [CMD_W-1:0]     fifo_din;
  logic                 fifo_wr_en;
  logic                 fifo_full = 1'b0, fifo_prog_full = 1'b0;
  logic [IW-1:0]        grant_id;
  logic                 busy, len_err;
  logic [31:0]          pkt_count;

  beat_t            src_q[N][$];
  exp_t             exp_q[$];
  logic [CMD_W-1:0] fifo_q[$];
  int               wr_cyc_q[$];
  int               checks = 0, errors = 0, cyc = 0;
  logic             drain_en = 1'b1, full_ovr = 1'b0, wr_pend = 1'b0;
  logic [CMD_W-1:0] wr_data = '0;
  exp_t             mon_e;

  us_cmd_arb #(.N(N), .CMD_W(CMD_W), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .grant_id(grant_id), .busy(busy),
    .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int s, input logic [7:0] tag, input int nb);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nb; k++) begin
      b.d = (128'(s) << 64) | 128'(tag + 8'(k));
      b.l = (k == nb - 1);
      src_q[s].push_back(b);
      e.d = b.d;
      e.src = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0 ||
            src_q[0].size() + src_q[1].size() + src_q[2].size() != 0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  // Environment: FIFO occupancy flags and source beat presentation, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (wr_pend) begin
      fifo_q.push_back(wr_data);
      wr_pend = 1'b0;
    end
    if (drain_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_full      = (fifo_q.size() >= DEPTH) || full_ovr;
    fifo_prog_full = (fifo_q.size() >= PF_TH);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*CMD_W +: CMD_W] = src_q[i][0].d;
        req_last[i] = src_q[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*CMD_W +: CMD_W] = '0;
        req_last[i] = 1'b0;
      end
    end
    #1;
    if (fifo_wr_en === 1'b1) begin
      wr_pend = 1'b1;
      wr_data = fifo_din;
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i] === 1'b1) void'(src_q[i].pop_front());
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    #1;
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fifo_din", fifo_din, mon_e.d);
        chk("grant_id", 128'(grant_id), 128'(mon_e.src));
      end
      wr_cyc_q.push_back(cyc);
    end else begin
      chk("din_zero_idle", fifo_din, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_ready", 128'(req_ready), 0);
    chk("rst_wr_en", 128'(fifo_wr_en), 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_grant", 128'(grant_id), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_len_err", 128'(len_err), 0);
    chk("rst_pkt_count", 128'(pkt_count), 0);
    step();
    rst = 1'b0;

    // Three single-beat packets from source 0.
    wr_cyc_q.delete();
    send(0, 8'h11, 1);
    send(0, 8'h22, 1);
    send(0, 8'h33, 1);
    wait_done("t1", 40);
    chk("t1_pkt_count", 128'(pkt_count), 3);
    chk("t1_nwrites", 128'(wr_cyc_q.size()), 3);
    if (wr_cyc_q.size() == 3) begin
      chk("t1_gap0", 128'(wr_cyc_q[1] - wr_cyc_q[0]), 2);
      chk("t1_gap1", 128'(wr_cyc_q[2] - wr_cyc_q[1]), 2);
    end

    // Reset so the pointer starts at 0, then all three sources contend.
    rst = 1'b1;
    #1;
    chk("t2_rst_pkt_count", 128'(pkt_count), 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++) send(s, 8'(8'h20 + k), 1);
    wait_done("t2", 60);
    chk("t2_pkt_count", 128'(pkt_count), 6);

    // Four-beat packet from source 1 stays contiguous ahead of source 2.
    send(1, 8'h30, 4);
    send(2, 8'h38, 1);
    wait_done("t3", 60);
    chk("t3_pkt_count", 128'(pkt_count), 8);
    chk("t3_len_err_at_max", 128'(len_err), 0);

    // prog_full blocks new grants until space is freed.
    begin
      int n;
      n = 0;
      while (fifo_q.size() != 0 && n < 50) begin step(); n++; end
      drain_en = 1'b0;
      for (int k = 0; k < 14; k++) send(0, 8'(8'h40 + k), 1);
      n = 0;
      while (fifo_q.size() < PF_TH && n < 80) begin step(); n++; end
      if (n >= 80) begin
        checks++;
        errors++;
        $display("FAIL t4_fill_timeout: got %0d entries expected %0d", fifo_q.size(), PF_TH);
      end
    end
    repeat (6) step();
    chk("t4_busy_blocked", 128'(busy), 0);
    chk("t4_ready_blocked", 128'(req_ready), 0);
    chk("t4_fifo_level", 128'(fifo_q.size()), PF_TH);
    chk("t4_pending", 128'(exp_q.size()), 2);
    repeat (4) void'(fifo_q.pop_front());
    step();
    chk("t4_busy_pf_edge", 128'(busy), 0);
    step();
    chk("t4_grant_after_pf", 128'(busy), 1);
    drain_en = 1'b1;
    wait_done("t4", 60);
    chk("t4_pkt_count", 128'(pkt_count), 22);

    // Overlong packet with a fifo_full stall in the middle.
    send(0, 8'h50, 5);
    step();
    step();
    full_ovr = 1'b1;
    step();
    chk("t5_full_wr_en", 128'(fifo_wr_en), 0);
    chk("t5_full_ready", 128'(req_ready), 0);
    chk("t5_full_busy", 128'(busy), 1);
    full_ovr = 1'b0;
    wait_done("t5", 60);
    chk("t5_len_err", 128'(len_err), 1);
    chk("t5_pkt_count", 128'(pkt_count), 23);
    repeat (3) step();
    chk("t5_len_err_sticky", 128'(len_err), 1);

    // Reset during beat 2 of a 3-beat packet.
    send(0, 8'h60, 3);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 128'(req_ready), 0);
    chk("t6_rst_wr_en", 128'(fifo_wr_en), 0);
    chk("t6_rst_din", fifo_din, 0);
    chk("t6_rst_busy", 128'(busy), 0);
    chk("t6_rst_len_err", 128'(len_err), 0);
    chk("t6_rst_pkt_count", 128'(pkt_count), 0);
    chk("t6_partial_beats", 128'(exp_q.size()), 1);
    src_q[0].delete();
    exp_q.delete();
    send(0, 8'h70, 1);
    send(1, 8'h71, 1);
    step();
    rst = 1'b0;
    wait_done("t6", 40);
    chk("t6_pkt_count", 128'(pkt_count), 2);

    chk("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
